instr_align_buffer: RTL and testbench

- Sits between the fetch stage and decode in the RV32IC pipeline.
- Consumes the stream of 32-bit aligned words produced by fetch.
- Re-slices that stream into whole instructions of 16 bits (compressed) or 32 bits, including 32-bit instructions that straddle a word boundary.
- Presents each instruction to decode with its PC and a compressed flag over a valid/ready handshake; supports pipeline flush/redirect to any halfword-aligned PC.

---
 rtl/instr_align_buffer.sv | 82 ++++++++
 tb/tb_instr_align_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instr_align_buffer.sv
// Instruction align buffer: re-slices fetched 32-bit words into 16/32-bit
// RV32IC instructions (including word-straddling ones) for decode.
module instr_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH_HW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_word,
  output logic        in_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic        out_compressed,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  // hw[0] is the head halfword; the queue is a packed array so a pop is a shift
  logic [DEPTH_HW-1:0][15:0] hw, hw_sh, hw_nx;
  logic [2:0]                count, count_nx, base, pop_n, push_n;
  logic [31:0]               pc_r;
  logic                      skip_low;
  logic                      head_c, has_instr, push, pop;

  assign head_c    = (hw[0][1:0] != 2'b11);
  assign has_instr = head_c ? (count >= 3'd1) : (count >= 3'd2);

  // Handshakes; in_ready looks only at current count so a full buffer never
  // depends on decode accepting in the same cycle
  assign out_valid      = ~flush & has_instr;
  assign in_ready       = ~reset & ~flush & (count <= 3'd2);
  assign out_instr      = head_c ? {16'h0, hw[0]} : {hw[1], hw[0]};
  assign out_compressed = head_c;
  assign out_pc         = pc_r;

  assign push   = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign pop_n  = pop ? (head_c ? 3'd1 : 3'd2) : 3'd0;
  assign push_n = push ? (skip_low ? 3'd1 : 3'd2) : 3'd0;
  assign base   = count - pop_n;

  // Next queue contents: drop popped halfwords, then append pushed ones
  // behind whatever survives the pop
  always_comb begin
    hw_sh = hw >> {pop_n, 4'b0000};
    hw_nx = hw_sh;
    if (push) begin
      for (int i = 0; i < DEPTH_HW; i++) begin
        if (skip_low) begin
          if (3'(i) == base) hw_nx[i] = in_word[31:16];
        end else begin
          if (3'(i) == base)        hw_nx[i] = in_word[15:0];
          if (3'(i) == base + 3'd1) hw_nx[i] = in_word[31:16];
        end
      end
    end
    count_nx = base + push_n;
  end

  // State update; reset beats flush, flush beats push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 3'd0;
      pc_r     <= RESET_PC;
      skip_low <= 1'b0;
      hw       <= '0;
    end else if (flush) begin
      count    <= 3'd0;
      pc_r     <= {flush_pc[31:1], 1'b0};
      skip_low <= flush_pc[1];
    end else begin
      count <= count_nx;
      hw    <= hw_nx;
      if (pop)  pc_r     <= pc_r + (head_c ? 32'd2 : 32'd4);
      if (push) skip_low <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_align_buffer.sv
// Directed bench for instr_align_buffer: hand-computed expectations per step.
module tb_instr_align_buffer;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_compressed, out_ready;
  logic [31:0] in_word, flush_pc, out_instr, out_pc;
  int          errors = 0;
  int          checks = 0;

  instr_align_buffer #(.RESET_PC(32'h0000_0000), .DEPTH_HW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word),
    .in_ready(in_ready), .flush(flush), .flush_pc(flush_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_compressed(out_compressed),
    .out_pc(out_pc), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge, then let comb logic settle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] instr,
                         input logic [31:0] pc, input logic c);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".instr"}, out_instr, instr);
    chk({tag, ".pc"}, out_pc, pc);
    chk({tag, ".comp"}, 32'(out_compressed), 32'(c));
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_word = '0; flush_pc = '0;
    cyc();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_word = '0; flush = 1'b0;
    flush_pc = '0; out_ready = 1'b0;
    cyc(); cyc();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_pc", out_pc, 32'h0);
    reset = 1'b0; #1;
    chk("rst_rel.in_ready", 32'(in_ready), 32'd1);

    // two 32-bit instructions
    out_ready = 1'b1; in_valid = 1'b1; in_word = 32'h0000_0513; #1;
    chk("t1.empty", 32'(out_valid), 32'd0);
    cyc();
    in_word = 32'h0010_0593; #1;
    chk_out("t1.i0", 32'h0000_0513, 32'h0, 1'b0);
    cyc();
    in_valid = 1'b0; #1;
    chk_out("t1.i1", 32'h0010_0593, 32'h4, 1'b0);
    cyc();
    chk("t1.drained", 32'(out_valid), 32'd0);

    // two compressed from one word
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_word = 32'h4505_4501;
    cyc();
    in_valid = 1'b0; #1;
    chk_out("t2.c0", 32'h0000_4501, 32'h0, 1'b1);
    cyc();
    chk_out("t2.c1", 32'h0000_4505, 32'h2, 1'b1);
    cyc();
    chk("t2.drained", 32'(out_valid), 32'd0);
    chk("t2.pc", out_pc, 32'h4);

    // straddling 32-bit instruction
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_word = 32'h0513_4501;
    cyc();
    in_valid = 1'b0; #1;
    chk_out("t3.c0", 32'h0000_4501, 32'h0, 1'b0 ^ 1'b1);
    cyc();
    chk("t3.hold", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_word = 32'h4585_0000; #1;
    chk("t3.hold_push", 32'(out_valid), 32'd0);
    cyc();
    in_valid = 1'b0; #1;
    chk_out("t3.straddle", 32'h0000_0513, 32'h2, 1'b0);
    cyc();
    chk_out("t3.c1", 32'h0000_4585, 32'h6, 1'b1);
    cyc();
    chk("t3.drained", 32'(out_valid), 32'd0);

    // backpressure: buffer fills, third word refused, drains in order
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_word = 32'h4505_4501;
    cyc();
    in_word = 32'h0010_0593; #1;
    chk("t4.rdy_cnt2", 32'(in_ready), 32'd1);
    cyc();
    in_word = 32'h1111_2222; #1;
    chk("t4.full_rdy", 32'(in_ready), 32'd0);
    chk_out("t4.full_head", 32'h0000_4501, 32'h0, 1'b1);
    cyc();
    chk("t4.full_rdy2", 32'(in_ready), 32'd0);
    chk_out("t4.full_head2", 32'h0000_4501, 32'h0, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1; #1;
    cyc();
    chk_out("t4.d1", 32'h0000_4505, 32'h2, 1'b1);
    cyc();
    chk_out("t4.d2", 32'h0010_0593, 32'h4, 1'b0);
    cyc();
    chk("t4.drained", 32'(out_valid), 32'd0);
    chk("t4.pc", out_pc, 32'h8);

    // flush to an odd-halfword PC while holding 3 halfwords
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_word = 32'h4505_4501;
    cyc();
    out_ready = 1'b1; in_word = 32'h0010_0593;
    cyc();
    flush = 1'b1; flush_pc = 32'h0000_0103; in_word = 32'h9999_9999; #1;
    chk("t5.fl_valid", 32'(out_valid), 32'd0);
    chk("t5.fl_rdy", 32'(in_ready), 32'd0);
    cyc();
    flush = 1'b0; in_word = 32'h4505_ABCD; #1;
    chk("t5.post_fl_valid", 32'(out_valid), 32'd0);
    chk("t5.post_fl_pc", out_pc, 32'h102);
    cyc();
    in_valid = 1'b0; #1;
    chk_out("t5.first", 32'h0000_4505, 32'h102, 1'b1);
    cyc();
    chk("t5.drained", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_word = 32'h0001_0001;
    cyc();
    in_valid = 1'b0; #1;
    chk_out("t5.skip_clr", 32'h0000_0001, 32'h104, 1'b1);

    // reset mid-stream with count=3
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_word = 32'h4505_4501;
    cyc();
    out_ready = 1'b1; in_word = 32'h0010_0593;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0; #1;
    chk_out("t6.pre", 32'h0000_4505, 32'h2, 1'b1);
    reset = 1'b1; flush = 1'b1; flush_pc = 32'h0000_0200; #1;
    chk("t6.rst_rdy", 32'(in_ready), 32'd0);
    cyc();
    reset = 1'b0; flush = 1'b0; #1;
    chk("t6.valid", 32'(out_valid), 32'd0);
    chk("t6.rdy", 32'(in_ready), 32'd1);
    chk("t6.pc", out_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
